// File: rtl/scale_pkg.sv
// Shared types, window limits and helper functions for the display scale control
// path and the downstream scale/window-gating datapath.
package scale_pkg;

  typedef logic [1:0] scale_t;

  localparam scale_t SCALE_SMALL = 2'd0;
  localparam scale_t SCALE_MED   = 2'd1;
  localparam scale_t SCALE_LARGE = 2'd2;

  localparam logic [10:0] H_LIM_SMALL = 11'd240;
  localparam logic [10:0] H_LIM_MED   = 11'd480;
  localparam logic [10:0] H_LIM_LARGE = 11'd640;
  localparam logic [9:0]  V_LIM_SMALL = 10'd320;
  localparam logic [9:0]  V_LIM_MED   = 10'd640;
  localparam logic [9:0]  V_LIM_LARGE = 10'd853;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
  } win_lim_t;

  typedef enum logic [1:0] {
    DB_RELEASED,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;

  // Button advance order; the reserved code 3 re-enters the cycle at MED.
  function automatic scale_t next_scale(input scale_t s);
    case (s)
      SCALE_SMALL: next_scale = SCALE_MED;
      SCALE_MED:   next_scale = SCALE_LARGE;
      SCALE_LARGE: next_scale = SCALE_SMALL;
      default:     next_scale = SCALE_MED;
    endcase
  endfunction

  function automatic scale_t sanitize_scale(input scale_t s);
    sanitize_scale = (s == 2'd3) ? SCALE_SMALL : s;
  endfunction

  // Inclusive visible limits; reserved code 3 uses the SMALL window.
  function automatic win_lim_t win_limits(input scale_t s);
    case (s)
      SCALE_MED:   win_limits = '{h: H_LIM_MED,   v: V_LIM_MED};
      SCALE_LARGE: win_limits = '{h: H_LIM_LARGE, v: V_LIM_LARGE};
      default:     win_limits = '{h: H_LIM_SMALL, v: V_LIM_SMALL};
    endcase
  endfunction

endpackage

// File: rtl/scale_ctrl_if.sv
// Control/pixel bundle between the host/pixel pipeline and scale_ctrl.
import scale_pkg::*;

interface scale_ctrl_if;
  // req_valid_in is a one-cycle strobe with no ready: scale_ctrl accepts every
  // request on the cycle it is asserted; the result shows up via pending_out.
  logic        btn_in;
  logic        req_valid_in;
  scale_t      req_scale_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  scale_t      scale_out;
  logic        pending_out;
  logic        in_window_out;
  db_state_t   db_state;

  modport slave (
    input  btn_in, req_valid_in, req_scale_in, hcount_in, vcount_in,
    output scale_out, pending_out, in_window_out, db_state
  );

  modport master (
    output btn_in, req_valid_in, req_scale_in, hcount_in, vcount_in,
    input  scale_out, pending_out, in_window_out, db_state
  );
endinterface

// File: rtl/btn_debounce.sv
// Four-state pushbutton debouncer; emits a one-cycle press pulse once the
// button has been stably high for DEBOUNCE_CYCLES cycles.
module btn_debounce
  import scale_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn,
  output logic      press,
  output db_state_t state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t     state;
  logic [CW-1:0] cnt;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DB_RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        DB_RELEASED: begin
          if (btn) begin
            state <= DB_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!btn) begin
            state <= DB_RELEASED;
          end else if (cnt == LAST) begin
            state <= DB_PRESSED;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_PRESSED: begin
          if (!btn) begin
            state <= DB_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          // A bounce back high is not a new press: no pulse on this return.
          if (btn) begin
            state <= DB_PRESSED;
          end else if (cnt == LAST) begin
            state <= DB_RELEASED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= DB_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/scale_ctrl.sv
// Display scale owner: collects button/host changes as pending and commits them
// only at the frame boundary; also flags pixels inside the committed window.
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int     DEBOUNCE_CYCLES = 500000,
  parameter scale_t SCALE_RESET     = 2'b00
) (
  input logic        clk_in,
  input logic        rst_n_in,
  scale_ctrl_if.slave bus
);

  logic     press;
  logic     boundary;
  scale_t   scale_q;
  scale_t   pend_scale;
  logic     pending_q;
  logic     in_win_q;
  win_lim_t lim;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .btn       (bus.btn_in),
    .press     (press),
    .state_dbg (bus.db_state)
  );

  assign boundary = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign lim      = win_limits(scale_q);

  assign bus.scale_out     = scale_q;
  assign bus.pending_out   = pending_q;
  assign bus.in_window_out = in_win_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scale_q    <= SCALE_RESET;
      pend_scale <= SCALE_SMALL;
      pending_q  <= 1'b0;
      in_win_q   <= 1'b0;
    end else begin
      in_win_q <= (bus.hcount_in <= lim.h) && (bus.vcount_in <= lim.v);

      if (boundary && pending_q) begin
        scale_q   <= pend_scale;
        pending_q <= 1'b0;
      end

      // Events come after the commit so one arriving on the boundary cycle
      // re-arms pending and waits for the following frame.
      if (bus.req_valid_in) begin
        pend_scale <= sanitize_scale(bus.req_scale_in);
        pending_q  <= 1'b1;
      end else if (press) begin
        pend_scale <= next_scale(pending_q ? pend_scale : scale_q);
        pending_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scale_ctrl.sv
// Self-checking bench for scale_ctrl: debounce, pending/commit sequencing,
// request priority and window edge vectors.
module tb_scale_ctrl;
  import scale_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scale_ctrl_if bus ();

  scale_ctrl #(.DEBOUNCE_CYCLES(8), .SCALE_RESET(2'b00)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [1:0]  scale;
    logic [10:0] h;
    logic [9:0]  v;
    logic        exp;
  } win_vec_t;

  win_vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame_boundary();
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    step();
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd5;
  endtask

  task automatic host_req(input logic [1:0] s);
    bus.req_valid_in = 1'b1;
    bus.req_scale_in = s;
    step();
    bus.req_valid_in = 1'b0;
  endtask

  // Long enough for the press pulse and a full release back to RELEASED.
  task automatic press_btn();
    bus.btn_in = 1'b1;
    repeat (12) step();
    bus.btn_in = 1'b0;
    repeat (12) step();
  endtask

  task automatic set_scale(input logic [1:0] s);
    host_req(s);
    frame_boundary();
    check("set_scale", bus.scale_out, s);
  endtask

  function automatic logic model_win(input logic [1:0] s, input logic [10:0] h, input logic [9:0] v);
    case (s)
      2'd1:    model_win = (h <= 11'd480) && (v <= 10'd640);
      2'd2:    model_win = (h <= 11'd640) && (v <= 10'd853);
      default: model_win = (h <= 11'd240) && (v <= 10'd320);
    endcase
  endfunction

  initial begin
    logic [1:0] cur;
    logic [0:0] e;

    vecs[0]  = '{2'd2, 11'd640,  10'd853,  1'b1};
    vecs[1]  = '{2'd2, 11'd641,  10'd853,  1'b0};
    vecs[2]  = '{2'd2, 11'd640,  10'd854,  1'b0};
    vecs[3]  = '{2'd2, 11'd300,  10'd700,  1'b1};
    vecs[4]  = '{2'd0, 11'd240,  10'd320,  1'b1};
    vecs[5]  = '{2'd0, 11'd241,  10'd0,    1'b0};
    vecs[6]  = '{2'd0, 11'd240,  10'd321,  1'b0};
    vecs[7]  = '{2'd1, 11'd480,  10'd640,  1'b1};
    vecs[8]  = '{2'd1, 11'd481,  10'd640,  1'b0};
    vecs[9]  = '{2'd1, 11'd480,  10'd641,  1'b0};
    vecs[10] = '{2'd1, 11'd0,    10'd0,    1'b1};
    vecs[11] = '{2'd1, 11'd2047, 10'd1023, 1'b0};

    // Reset
    bus.btn_in       = 1'b0;
    bus.req_valid_in = 1'b0;
    bus.req_scale_in = 2'd0;
    bus.hcount_in    = 11'd100;
    bus.vcount_in    = 10'd100;
    repeat (3) step();
    check("rst_scale", bus.scale_out, 0);
    check("rst_pending", bus.pending_out, 0);
    check("rst_in_window", bus.in_window_out, 0);
    check("rst_db_state", bus.db_state, DB_RELEASED);
    rst_n = 1'b1;
    step();
    check("post_rst_in_window", bus.in_window_out, 1);
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd5;
    step();

    // Short glitch is rejected
    bus.btn_in = 1'b1;
    repeat (5) step();
    bus.btn_in = 1'b0;
    repeat (12) step();
    check("glitch_pending", bus.pending_out, 0);
    check("glitch_db_state", bus.db_state, DB_RELEASED);

    // Debounced press waits for the frame boundary
    press_btn();
    check("press_pending", bus.pending_out, 1);
    check("press_scale_held", bus.scale_out, 0);
    frame_boundary();
    check("press_commit_scale", bus.scale_out, 1);
    check("press_commit_pending", bus.pending_out, 0);

    // Accumulation within one frame
    set_scale(2'd0);
    press_btn();
    press_btn();
    check("accum_scale_held", bus.scale_out, 0);
    frame_boundary();
    check("accum_commit", bus.scale_out, 2);
    press_btn();
    frame_boundary();
    check("accum_wrap", bus.scale_out, 0);

    // Host request beats a simultaneous press (pulse lands on the 10th edge)
    bus.btn_in = 1'b1;
    repeat (9) step();
    host_req(2'd2);
    check("prio_db_state", bus.db_state, DB_PRESSED);
    bus.btn_in = 1'b0;
    repeat (12) step();
    check("prio_pending", bus.pending_out, 1);
    frame_boundary();
    check("prio_commit", bus.scale_out, 2);

    // Reserved request value
    host_req(2'd3);
    frame_boundary();
    check("req3_commit", bus.scale_out, 0);

    // Request on the boundary cycle waits a full frame
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    host_req(2'd1);
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd5;
    check("coinc_scale_held", bus.scale_out, 0);
    check("coinc_pending", bus.pending_out, 1);
    repeat (3) step();
    check("coinc_scale_still", bus.scale_out, 0);
    frame_boundary();
    check("coinc_commit", bus.scale_out, 1);
    check("coinc_pending_clr", bus.pending_out, 0);

    // Window edge table
    cur = bus.scale_out;
    for (int i = 0; i < 12; i++) begin
      if (cur != vecs[i].scale) begin
        set_scale(vecs[i].scale);
        cur = vecs[i].scale;
      end
      bus.hcount_in = vecs[i].h;
      bus.vcount_in = vecs[i].v;
      exp_q.push_back(vecs[i].exp);
      step();
      e = exp_q.pop_front();
      check($sformatf("win_vec%0d", i), bus.in_window_out, e);
    end

    // Random pixel stream against the window model (scale 0 and 2)
    for (int k = 0; k < 2; k++) begin
      cur = (k == 0) ? 2'd0 : 2'd2;
      set_scale(cur);
      for (int j = 0; j < 30; j++) begin
        bus.hcount_in = 11'($urandom_range(1000, 1));
        bus.vcount_in = 10'($urandom_range(1000, 1));
        exp_q.push_back(model_win(cur, bus.hcount_in, bus.vcount_in));
        step();
        e = exp_q.pop_front();
        check("win_rand", bus.in_window_out, e);
      end
    end
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd5;

    // Reset mid-pending and mid-debounce discards everything
    host_req(2'd1);
    bus.btn_in = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    check("midrst_scale", bus.scale_out, 0);
    check("midrst_pending", bus.pending_out, 0);
    check("midrst_db_state", bus.db_state, DB_RELEASED);
    bus.btn_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    frame_boundary();
    check("midrst_no_commit", bus.scale_out, 0);
    check("midrst_no_pending", bus.pending_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
